axi_demo_initiator: RTL

// AXI4 write/read initiator pairing with the uConsumer responder in the axiDemo system (addr_id_top).
// On start, issues NUM_XFERS single-beat writes (addr = base + 4*i, data = seed + i), then reads each back.

---
 rtl/axi_demo_initiator.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/axi_demo_initiator.sv
// AXI4 single-beat write-then-readback initiator: writes NUM_XFERS words derived
// from a seed, reads them back, and counts mismatches and non-OKAY responses.
module axi_demo_initiator #(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned STRB_W    = 4,
    parameter int unsigned NUM_XFERS = 8,
    parameter int unsigned CNT_W     = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] base_addr_i,
    input  logic [DATA_W-1:0] seed_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [CNT_W-1:0]  err_cnt_o,
    output logic              awvalid,
    input  logic              awready,
    output logic [ADDR_W-1:0] awaddr,
    output logic              wvalid,
    input  logic              wready,
    output logic [DATA_W-1:0] wdata,
    output logic [STRB_W-1:0] wstrb,
    output logic              wlast,
    input  logic              bvalid,
    output logic              bready,
    input  logic [1:0]        bresp,
    output logic              arvalid,
    input  logic              arready,
    output logic [ADDR_W-1:0] araddr,
    input  logic              rvalid,
    output logic              rready,
    input  logic [DATA_W-1:0] rdata,
    input  logic [1:0]        rresp
);

    typedef enum logic [2:0] {IDLE, WADDR, WRESP, RADDR, RDATA, DONE} state_t;

    state_t            state;
    logic [ADDR_W-1:0] base;
    logic [DATA_W-1:0] seed;
    logic [CNT_W-1:0]  idx;
    logic [CNT_W-1:0]  err_cnt;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] word;
    logic              last;

    // Address and data derive only from registers that are frozen while a
    // valid is pending, so they stay stable until the handshake.
    assign addr      = base + (ADDR_W'(idx) << 2);
    assign word      = seed + DATA_W'(idx);
    assign last      = (idx == CNT_W'(NUM_XFERS - 1));
    assign awaddr    = addr;
    assign araddr    = addr;
    assign wdata     = word;
    assign wstrb     = '1;
    assign wlast     = 1'b1;
    assign err_cnt_o = err_cnt;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            base    <= '0;
            seed    <= '0;
            idx     <= '0;
            err_cnt <= '0;
            awvalid <= 1'b0;
            wvalid  <= 1'b0;
            bready  <= 1'b0;
            arvalid <= 1'b0;
            rready  <= 1'b0;
            busy_o  <= 1'b0;
            done_o  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done_o <= 1'b0;
                    if (start_i) begin
                        base    <= base_addr_i;
                        seed    <= seed_i;
                        idx     <= '0;
                        err_cnt <= '0;
                        busy_o  <= 1'b1;
                        awvalid <= 1'b1;
                        wvalid  <= 1'b1;
                        state   <= WADDR;
                    end
                end
                WADDR: begin
                    if (awvalid && awready) awvalid <= 1'b0;
                    if (wvalid && wready)   wvalid  <= 1'b0;
                    // A dropped valid means that channel already completed.
                    if ((!awvalid || awready) && (!wvalid || wready)) begin
                        bready <= 1'b1;
                        state  <= WRESP;
                    end
                end
                WRESP: begin
                    if (bvalid) begin
                        bready <= 1'b0;
                        if (bresp != 2'b00) err_cnt <= sat_inc(err_cnt);
                        if (last) begin
                            idx     <= '0;
                            arvalid <= 1'b1;
                            state   <= RADDR;
                        end else begin
                            idx     <= idx + 1'b1;
                            awvalid <= 1'b1;
                            wvalid  <= 1'b1;
                            state   <= WADDR;
                        end
                    end
                end
                RADDR: begin
                    if (arready) begin
                        arvalid <= 1'b0;
                        rready  <= 1'b1;
                        state   <= RDATA;
                    end
                end
                RDATA: begin
                    if (rvalid) begin
                        rready <= 1'b0;
                        if (rresp != 2'b00 || rdata != word) err_cnt <= sat_inc(err_cnt);
                        if (last) begin
                            busy_o <= 1'b0;
                            done_o <= 1'b1;
                            state  <= DONE;
                        end else begin
                            idx     <= idx + 1'b1;
                            arvalid <= 1'b1;
                            state   <= RADDR;
                        end
                    end
                end
                DONE: begin
                    done_o <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
